// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the memory-mapped UART transmitter:
//   - bus addresses of the TXD and UART_CON registers
//   - bit position of the sticky overflow flag in UART_CON
//   - transmit FSM state encoding
//   - helper that packs the UART_CON status word
package uart_pkg;

    localparam logic [31:0] TXD_ADDR      = 32'h4000_0018;
    localparam logic [31:0] UART_CON_ADDR = 32'h4000_0020;

    // Writing a 1 to this bit of UART_CON clears the overflow flag.
    localparam int CON_OVF_BIT = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // UART_CON read layout: {28'h0, overflow, fifo_empty, fifo_full, busy}
    function automatic logic [31:0] pack_status(input logic overflow,
                                                input logic fifo_empty,
                                                input logic fifo_full,
                                                input logic busy);
        return {28'h0, overflow, fifo_empty, fifo_full, busy};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with first-word-fall-through head output.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     push, push_data write request and data
//     pop             read request (ignored when empty)
//     head_data       oldest entry, valid while empty=0
//     full, empty     occupancy flags
//     count           current occupancy, 0..DEPTH
//   DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // A push into a full FIFO is still taken when a pop frees a slot in the same cycle.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio
//   Memory-mapped 8N1 UART transmitter with a byte FIFO.
//   Ports:
//     clk, reset_n          clock, asynchronous active-low reset
//     Address, Write_data   shared data-bus address and store data
//     MemRead, MemWrite     load / store strobes
//     Read_data             combinational load data (0 unless UART_CON is read)
//     uart_tx               serial output, idle high
//     tx_irq                level interrupt: FIFO empty and transmitter idle
//   Registers:
//     TXD      (0x40000018) write pushes Write_data[7:0]; reads as 0
//     UART_CON (0x40000020) read {28'h0, overflow, fifo_empty, fifo_full, busy};
//                           write with bit 3 set clears overflow
//   BAUD_DIV must be at least 2.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = 10417,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] Read_data,
    output logic        uart_tx,
    output logic        tx_irq
);

    localparam int             CW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0]  BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam int             FCW       = $clog2(FIFO_DEPTH) + 1;

    tx_state_e     state_q, state_d;
    logic [CW-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          overflow_q, overflow_d;

    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [7:0]     fifo_head;
    logic [FCW-1:0] fifo_count;

    logic txd_sel, con_sel, txd_write, con_write;
    logic busy, baud_done;

    assign txd_sel   = (Address == TXD_ADDR);
    assign con_sel   = (Address == UART_CON_ADDR);
    assign txd_write = MemWrite & txd_sel;
    assign con_write = MemWrite & con_sel;

    assign busy      = (state_q != ST_IDLE);
    assign baud_done = (baud_cnt_q == BAUD_LAST);

    assign uart_tx = tx_q;
    assign tx_irq  = fifo_empty & ~busy;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset_n),
        .push      (txd_write),
        .push_data (Write_data[7:0]),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Only bit 3 of a UART_CON store and the low byte of a TXD store carry meaning.
    logic unused_bits;
    assign unused_bits = ^{Write_data[31:8], fifo_count};

    // Next-state logic. tx_d is the line level for the state being entered,
    // so uart_tx changes on the same edge as the state register. The shift
    // register keeps the current bit in [0]; entering the next data bit
    // therefore sends shift_q[1] while the register shifts right.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q + CW'(1);
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        fifo_pop   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                baud_cnt_d = '0;
                tx_d       = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    state_d  = ST_START;
                    tx_d     = 1'b0;
                end
            end
            ST_START: begin
                if (baud_done) begin
                    state_d    = ST_DATA;
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    tx_d       = shift_q[0];
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    baud_cnt_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end
            end
            ST_STOP: begin
                if (baud_done) begin
                    baud_cnt_d = '0;
                    // Chain straight into the next frame when data is waiting.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        state_d  = ST_START;
                        tx_d     = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                baud_cnt_d = '0;
                tx_d       = 1'b1;
            end
        endcase
    end

    // Sticky overflow: a TXD store the FIFO could not take sets it, and it
    // wins over a clear request arriving in the same cycle.
    always_comb begin
        overflow_d = overflow_q;
        if (con_write && Write_data[CON_OVF_BIT]) begin
            overflow_d = 1'b0;
        end
        if (txd_write && fifo_full && !fifo_pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        Read_data = 32'h0;
        if (MemRead && con_sel) begin
            Read_data = pack_status(overflow_q, fifo_empty, fifo_full, busy);
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio
//   Scoreboard bench for uart_tx_mmio with BAUD_DIV=4. Every byte accepted
//   into the transmitter is queued as an expected frame; an independent line
//   monitor recognises start bits, pops the queue and compares the line level
//   in every clock slot of the frame against an ideal 8N1 waveform.
module tb_uart_tx_mmio;

    localparam int BAUD        = 4;
    localparam int DEPTH       = 8;
    localparam int FRAME_SLOTS = 10 * BAUD;

    localparam logic [31:0] A_TXD   = 32'h4000_0018;
    localparam logic [31:0] A_CON   = 32'h4000_0020;
    localparam logic [31:0] A_OTHER = 32'h4000_0024;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic [31:0] Address    = 32'h0;
    logic [31:0] Write_data = 32'h0;
    logic        MemRead    = 1'b0;
    logic        MemWrite   = 1'b0;
    logic [31:0] Read_data;
    logic        uart_tx;
    logic        tx_irq;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    bit         mon_busy    = 1'b0;
    bit         gap_pending = 1'b0;
    int         slot        = 0;
    logic [7:0] cur_byte    = 8'h0;

    uart_tx_mmio #(
        .BAUD_DIV   (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .Address    (Address),
        .Write_data (Write_data),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Read_data  (Read_data),
        .uart_tx    (uart_tx),
        .tx_irq     (tx_irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", name, actual, expected);
        end
    endtask

    // Ideal 8N1 line level for a given clock slot of a frame carrying b.
    function automatic logic idealLine(input logic [7:0] b, input int s);
        if (s < BAUD) return 1'b0;
        if (s < 9 * BAUD) return b[(s - BAUD) / BAUD];
        return 1'b1;
    endfunction

    // One bus cycle: drive at the falling edge, sample Read_data 1 ns later,
    // let the rising edge act, then drop the strobes.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] addr,
                                 input logic [31:0] wdata, input bit expect_push,
                                 output logic [31:0] rdata);
        @(negedge clk);
        MemWrite   = wr;
        MemRead    = rd;
        Address    = addr;
        Write_data = wdata;
        #1 rdata = Read_data;
        @(posedge clk);
        if (expect_push) exp_q.push_back(wdata[7:0]);
        #1;
        MemWrite = 1'b0;
        MemRead  = 1'b0;
    endtask

    task automatic readCheck(input string name, input logic [31:0] addr,
                             input logic [31:0] expected);
        logic [31:0] rd;
        applyStimulus(1'b0, 1'b1, addr, 32'h0, 1'b0, rd);
        checkOutput(name, rd, expected);
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data, input bit expect_push);
        logic [31:0] rd;
        applyStimulus(1'b1, 1'b0, addr, data, expect_push, rd);
    endtask

    // Bounded wait until all expected frames went out and the DUT reports idle.
    task automatic waitIdle(input string name);
        int n = 0;
        while (!(exp_q.size() == 0 && !mon_busy && tx_irq === 1'b1) && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++;
        if (n >= 3000) begin
            bad++;
            $display("[TB] FAIL %s timeout got=%0d pending exp=0", name, exp_q.size());
        end
    endtask

    // Line monitor: independent of the stimulus, sampled on falling edges.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                mon_busy    = 1'b0;
                gap_pending = 1'b0;
                exp_q.delete();
            end else if (mon_busy) begin
                slot++;
                checkOutput($sformatf("frame_slot%0d", slot), 32'(uart_tx),
                            32'(idealLine(cur_byte, slot)));
                checkOutput("irq_during_frame", 32'(tx_irq), 32'd0);
                if (slot == FRAME_SLOTS - 1) begin
                    mon_busy    = 1'b0;
                    gap_pending = (exp_q.size() > 0);
                end
            end else begin
                if (gap_pending) begin
                    checkOutput("back_to_back_start", 32'(uart_tx), 32'd0);
                    gap_pending = 1'b0;
                end
                if (uart_tx === 1'b0) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpected_start got=start exp=idle");
                    end else begin
                        cur_byte = exp_q.pop_front();
                        slot     = 0;
                        mon_busy = 1'b1;
                        checkOutput("irq_at_start", 32'(tx_irq), 32'd0);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        logic [31:0] rd;
        logic [7:0]  b;

        // Reset state
        #23;
        checkOutput("reset_line", 32'(uart_tx), 32'd1);
        checkOutput("reset_irq", 32'(tx_irq), 32'd1);
        MemRead = 1'b1;
        Address = A_CON;
        #1 checkOutput("reset_status", Read_data, 32'h4);
        MemRead = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b1;

        // Decode: TXD reads 0, unmapped reads 0, no MemRead gives 0
        readCheck("read_txd", A_TXD, 32'h0);
        readCheck("read_other", A_OTHER, 32'h0);
        applyStimulus(1'b0, 1'b0, A_CON, 32'h0, 1'b0, rd);
        checkOutput("con_no_memread", rd, 32'h0);
        readCheck("idle_status", A_CON, 32'h4);
        store(A_OTHER, 32'h0000_00FF, 1'b0);
        store(32'h4000_001C, 32'h0000_0055, 1'b0);

        // Single byte 0xA5; the pushed byte is not popped on the same edge
        store(A_TXD, 32'h0000_00A5, 1'b1);
        readCheck("status_after_push", A_CON, 32'h0);
        readCheck("status_sending", A_CON, 32'h5);
        waitIdle("drain_a5");
        readCheck("status_after_a5", A_CON, 32'h4);

        // Two bytes chained without an idle gap
        store(A_TXD, 32'h0000_0001, 1'b1);
        store(A_TXD, 32'h0000_0002, 1'b1);
        waitIdle("drain_pair");

        // Nine stores fit (one popped, eight queued); the tenth overflows
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            store(A_TXD, {24'h0, b}, (i < 9));
        end
        readCheck("overflow_status", A_CON, 32'hB);
        store(A_CON, 32'h0000_0007, 1'b0);
        readCheck("clear_needs_bit3", A_CON, 32'hB);
        store(A_CON, 32'h0000_0008, 1'b0);
        readCheck("overflow_cleared", A_CON, 32'h3);
        waitIdle("drain_overflow");
        readCheck("status_after_drain", A_CON, 32'h4);

        // Randomized traffic, never more queued than the FIFO can hold
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    if (exp_q.size() < DEPTH) begin
                        store(A_TXD, $urandom, 1'b1);
                    end
                end
                2: begin
                    store(A_OTHER, $urandom, 1'b0);
                    readCheck("rand_read_txd", A_TXD, 32'h0);
                end
                default: begin
                    applyStimulus(1'b0, 1'b1, A_CON, 32'h0, 1'b0, rd);
                    checkOutput("rand_status_hi", rd & 32'hFFFF_FFF8, 32'h0);
                end
            endcase
            repeat ($urandom_range(0, 30)) @(posedge clk);
        end
        waitIdle("drain_random");
        readCheck("status_after_random", A_CON, 32'h4);

        // Reset during data bit 3 of 0xA5 (line is low there)
        store(A_TXD, 32'h0000_00A5, 1'b1);
        repeat (19) @(posedge clk);
        #2 reset_n = 1'b0;
        MemRead = 1'b1;
        Address = A_CON;
        #1;
        checkOutput("abort_line", 32'(uart_tx), 32'd1);
        checkOutput("abort_status", Read_data, 32'h4);
        MemRead = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("irq_after_abort", 32'(tx_irq), 32'd1);
        checkOutput("line_after_abort", 32'(uart_tx), 32'd1);
        repeat (20) @(posedge clk);
        readCheck("status_after_abort", A_CON, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
